// File: rtl/barrel_normalize.sv
// Iterative normalizer: shifts the operand one binary-search stage per cycle until its
// leading one sits at the MSB (LEFT=1) or LSB (LEFT=0), reporting the total shift amount.
module barrel_normalize #(
    parameter int LENGTH = 8,
    parameter bit LEFT   = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LENGTH-1:0]           data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LENGTH-1:0]           data_out,
    output logic [$clog2(LENGTH)-1:0]   shamt,
    output logic                        zero,
    output logic [1:0]                  state_dbg
);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never
    // depends combinationally on ready, and results stay frozen while out_valid waits.

    localparam int S = $clog2(LENGTH);
    localparam logic [S-1:0] LAST_STEP = S'(S - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LENGTH-1:0] work_q, work_d;
    logic [S-1:0]      shamt_q, shamt_d;
    logic [S-1:0]      step_q, step_d;
    logic              zero_q, zero_d;

    logic [S-1:0]      stage_k;
    logic [S:0]        width;
    logic [LENGTH-1:0] test_mask;
    logic              stage_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            work_q  <= '0;
            shamt_q <= '0;
            step_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            step_q  <= step_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (step_q == LAST_STEP) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage k examines the 2^k bits on the side the leading one must reach.
    always_comb begin
        stage_k     = LAST_STEP - step_q;
        width       = (S+1)'(1) << stage_k;
        test_mask   = LEFT ? ~({LENGTH{1'b1}} >> width) : ~({LENGTH{1'b1}} << width);
        stage_empty = (work_q & test_mask) == '0;
    end

    always_comb begin
        work_d  = work_q;
        shamt_d = shamt_q;
        step_d  = step_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = data_in;
                    shamt_d = '0;
                    step_d  = '0;
                    zero_d  = (data_in == '0);
                end
            end
            RUN: begin
                if (stage_empty) begin
                    work_d           = LEFT ? (work_q << width) : (work_q >> width);
                    shamt_d[stage_k] = 1'b1;
                end
                step_d = step_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = reset && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign data_out  = work_q;
    assign shamt     = shamt_q;
    assign zero      = zero_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_barrel_normalize.sv
// Bench for barrel_normalize: four instances (LENGTH 8/16, LEFT 1/0) checked against a
// leading/trailing-one reference model, plus directed latency, backpressure and reset cases.
module tb_barrel_normalize;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid_a [4];
  logic        out_ready_a[4];
  logic [15:0] data_in_a  [4];
  logic        in_ready_a [4];
  logic        out_valid_a[4];
  logic        zero_a     [4];
  logic [15:0] data_out_a [4];
  logic [3:0]  shamt_a    [4];

  logic        ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3, z0, z1, z2, z3;
  logic [7:0]  dout0, dout1;
  logic [15:0] dout2, dout3;
  logic [2:0]  sh0, sh1;
  logic [3:0]  sh2, sh3;
  logic [1:0]  st0, st1, st2, st3;

  int n_cmp  = 0;
  int n_fail = 0;

  int len_a [4] = '{8, 8, 16, 16};
  bit left_a[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int s_a   [4] = '{3, 3, 4, 4};

  always #5 clk = ~clk;

  barrel_normalize #(.LENGTH(8), .LEFT(1'b1)) u_l8 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_a[0]), .in_ready(ir0),
    .data_in(data_in_a[0][7:0]), .out_valid(ov0), .out_ready(out_ready_a[0]),
    .data_out(dout0), .shamt(sh0), .zero(z0), .state_dbg(st0)
  );
  barrel_normalize #(.LENGTH(8), .LEFT(1'b0)) u_r8 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_a[1]), .in_ready(ir1),
    .data_in(data_in_a[1][7:0]), .out_valid(ov1), .out_ready(out_ready_a[1]),
    .data_out(dout1), .shamt(sh1), .zero(z1), .state_dbg(st1)
  );
  barrel_normalize #(.LENGTH(16), .LEFT(1'b1)) u_l16 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_a[2]), .in_ready(ir2),
    .data_in(data_in_a[2]), .out_valid(ov2), .out_ready(out_ready_a[2]),
    .data_out(dout2), .shamt(sh2), .zero(z2), .state_dbg(st2)
  );
  barrel_normalize #(.LENGTH(16), .LEFT(1'b0)) u_r16 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid_a[3]), .in_ready(ir3),
    .data_in(data_in_a[3]), .out_valid(ov3), .out_ready(out_ready_a[3]),
    .data_out(dout3), .shamt(sh3), .zero(z3), .state_dbg(st3)
  );

  always_comb begin
    in_ready_a[0] = ir0;  in_ready_a[1] = ir1;  in_ready_a[2] = ir2;  in_ready_a[3] = ir3;
    out_valid_a[0] = ov0; out_valid_a[1] = ov1; out_valid_a[2] = ov2; out_valid_a[3] = ov3;
    zero_a[0] = z0; zero_a[1] = z1; zero_a[2] = z2; zero_a[3] = z3;
    data_out_a[0] = {8'h00, dout0};
    data_out_a[1] = {8'h00, dout1};
    data_out_a[2] = dout2;
    data_out_a[3] = dout3;
    shamt_a[0] = {1'b0, sh0};
    shamt_a[1] = {1'b0, sh1};
    shamt_a[2] = sh2;
    shamt_a[3] = sh3;
  end

  // Reference: locate the highest (LEFT) or lowest (RIGHT) set bit and shift it to the edge.
  function automatic void ref_model(input int len, input bit left, input logic [15:0] op,
                                    output logic [15:0] d, output logic [3:0] sh,
                                    output logic z);
    logic [15:0] mask;
    int pos;
    mask = (len == 16) ? 16'hFFFF : 16'h00FF;
    z = (op == 16'h0000);
    pos = 0;
    if (z) begin
      d = 16'h0000;
      sh = 4'(len - 1);
    end else if (left) begin
      for (int i = 0; i < len; i++) if (op[i]) pos = i;
      sh = 4'(len - 1 - pos);
      d = (op << sh) & mask;
    end else begin
      for (int i = len - 1; i >= 0; i--) if (op[i]) pos = i;
      sh = 4'(pos);
      d = op >> sh;
    end
  endfunction

  // Drives one operand through instance idx; lat is cycles from accept to out_valid (-1 on timeout).
  task automatic run_op(input int idx, input logic [15:0] op, input int hold,
                        output logic [15:0] d, output logic [3:0] sh, output logic z,
                        output int lat, output logic rdy_after);
    int guard;
    lat = -1; d = '0; sh = '0; z = 1'b0; rdy_after = 1'b0;
    guard = 0;
    while (!in_ready_a[idx] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    in_valid_a[idx]  = 1'b1;
    data_in_a[idx]   = op;
    out_ready_a[idx] = (hold == 0);
    @(posedge clk); #1;
    in_valid_a[idx] = 1'b0;
    guard = 0;
    while (!out_valid_a[idx] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (out_valid_a[idx]) lat = guard;
    d  = data_out_a[idx];
    sh = shamt_a[idx];
    z  = zero_a[idx];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    out_ready_a[idx] = 1'b1;
    @(posedge clk); #1;
    rdy_after = in_ready_a[idx];
    out_ready_a[idx] = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      n_cmp += 5;
      if (in_ready_a[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_in_ready[%0d]: got %b exp 0", i, in_ready_a[i]);
      end
      if (out_valid_a[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_out_valid[%0d]: got %b exp 0", i, out_valid_a[i]);
      end
      if (data_out_a[i] !== 16'h0) begin
        n_fail++; $display("FAIL reset_data_out[%0d]: got %h exp 0", i, data_out_a[i]);
      end
      if (shamt_a[i] !== 4'h0) begin
        n_fail++; $display("FAIL reset_shamt[%0d]: got %0d exp 0", i, shamt_a[i]);
      end
      if (zero_a[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_zero[%0d]: got %b exp 0", i, zero_a[i]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (in_ready_a[i] !== 1'b1) begin
        n_fail++; $display("FAIL idle_in_ready[%0d]: got %b exp 1", i, in_ready_a[i]);
      end
    end
  endtask

  task automatic test_basic();
    logic [15:0] d; logic [3:0] sh; logic z; int lat; logic rdy;
    run_op(0, 16'h0016, 0, d, sh, z, lat, rdy);
    n_cmp += 5;
    if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d exp 3", lat); end
    if (d !== 16'h00B0) begin n_fail++; $display("FAIL basic_dout: got %h exp b0", d); end
    if (sh !== 4'd3) begin n_fail++; $display("FAIL basic_shamt: got %0d exp 3", sh); end
    if (z !== 1'b0) begin n_fail++; $display("FAIL basic_zero: got %b exp 0", z); end
    if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after: got %b exp 1", rdy); end
  endtask

  task automatic test_left_edges();
    logic [15:0] ops  [3] = '{16'h0080, 16'h0001, 16'h0000};
    logic [15:0] exp_d[3] = '{16'h0080, 16'h0080, 16'h0000};
    logic [3:0]  exp_s[3] = '{4'd0, 4'd7, 4'd7};
    logic        exp_z[3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] d; logic [3:0] sh; logic z; int lat; logic rdy;
    for (int i = 0; i < 3; i++) begin
      run_op(0, ops[i], 0, d, sh, z, lat, rdy);
      n_cmp += 4;
      if (d !== exp_d[i]) begin n_fail++; $display("FAIL ledge_dout[%h]: got %h exp %h", ops[i], d, exp_d[i]); end
      if (sh !== exp_s[i]) begin n_fail++; $display("FAIL ledge_shamt[%h]: got %0d exp %0d", ops[i], sh, exp_s[i]); end
      if (z !== exp_z[i]) begin n_fail++; $display("FAIL ledge_zero[%h]: got %b exp %b", ops[i], z, exp_z[i]); end
      if (lat !== 3) begin n_fail++; $display("FAIL ledge_latency[%h]: got %0d exp 3", ops[i], lat); end
    end
  endtask

  task automatic test_right();
    logic [15:0] ops  [2] = '{16'h0068, 16'h0080};
    logic [15:0] exp_d[2] = '{16'h000D, 16'h0001};
    logic [3:0]  exp_s[2] = '{4'd3, 4'd7};
    logic [15:0] d; logic [3:0] sh; logic z; int lat; logic rdy;
    for (int i = 0; i < 2; i++) begin
      run_op(1, ops[i], 0, d, sh, z, lat, rdy);
      n_cmp += 4;
      if (d !== exp_d[i]) begin n_fail++; $display("FAIL right_dout[%h]: got %h exp %h", ops[i], d, exp_d[i]); end
      if (sh !== exp_s[i]) begin n_fail++; $display("FAIL right_shamt[%h]: got %0d exp %0d", ops[i], sh, exp_s[i]); end
      if (z !== 1'b0) begin n_fail++; $display("FAIL right_zero[%h]: got %b exp 0", ops[i], z); end
      if (lat !== 3) begin n_fail++; $display("FAIL right_latency[%h]: got %0d exp 3", ops[i], lat); end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    in_valid_a[0] = 1'b1; data_in_a[0] = 16'h0016; out_ready_a[0] = 1'b0;
    @(posedge clk); #1;
    data_in_a[0] = 16'h0003;
    guard = 0;
    while (!out_valid_a[0] && guard < 50) begin @(posedge clk); #1; guard++; end
    n_cmp++;
    if (guard !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d exp 3", guard); end
    for (int c = 0; c < 5; c++) begin
      n_cmp += 4;
      if (out_valid_a[0] !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b exp 1", c, out_valid_a[0]); end
      if (data_out_a[0] !== 16'h00B0) begin n_fail++; $display("FAIL bp_hold_dout[%0d]: got %h exp b0", c, data_out_a[0]); end
      if (shamt_a[0] !== 4'd3) begin n_fail++; $display("FAIL bp_hold_shamt[%0d]: got %0d exp 3", c, shamt_a[0]); end
      if (in_ready_a[0] !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready[%0d]: got %b exp 0", c, in_ready_a[0]); end
      @(posedge clk); #1;
    end
    out_ready_a[0] = 1'b1;
    @(posedge clk); #1;
    n_cmp += 2;
    if (out_valid_a[0] !== 1'b0) begin n_fail++; $display("FAIL bp_after_hs_valid: got %b exp 0", out_valid_a[0]); end
    if (in_ready_a[0] !== 1'b1) begin n_fail++; $display("FAIL bp_after_hs_ready: got %b exp 1", in_ready_a[0]); end
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n_cmp++;
    if (in_ready_a[0] !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept: got %b exp 0", in_ready_a[0]); end
    guard = 0;
    while (!out_valid_a[0] && guard < 50) begin @(posedge clk); #1; guard++; end
    n_cmp += 3;
    if (guard !== 3) begin n_fail++; $display("FAIL bp_second_latency: got %0d exp 3", guard); end
    if (data_out_a[0] !== 16'h00C0) begin n_fail++; $display("FAIL bp_second_dout: got %h exp c0", data_out_a[0]); end
    if (shamt_a[0] !== 4'd6) begin n_fail++; $display("FAIL bp_second_shamt: got %0d exp 6", shamt_a[0]); end
    @(posedge clk); #1;
    out_ready_a[0] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    in_valid_a[0] = 1'b1; data_in_a[0] = 16'h0016; out_ready_a[0] = 1'b0;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp += 4;
    if (out_valid_a[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b exp 0", out_valid_a[0]); end
    if (data_out_a[0] !== 16'h0) begin n_fail++; $display("FAIL midrst_dout: got %h exp 0", data_out_a[0]); end
    if (shamt_a[0] !== 4'h0) begin n_fail++; $display("FAIL midrst_shamt: got %0d exp 0", shamt_a[0]); end
    if (in_ready_a[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b exp 0", in_ready_a[0]); end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready_a[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_release_ready: got %b exp 1", in_ready_a[0]); end
    out_ready_a[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      n_cmp++;
      if (out_valid_a[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d]: got %b exp 0", c, out_valid_a[0]); end
      @(posedge clk); #1;
    end
    out_ready_a[0] = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] op, mask, d, ed, inv; logic [3:0] sh, es; logic z, ez, rdy, edge_bit;
    int lat, len; bit left;
    for (int idx = 0; idx < 4; idx++) begin
      len = len_a[idx]; left = left_a[idx];
      mask = (len == 16) ? 16'hFFFF : 16'h00FF;
      for (int n = 0; n < 100; n++) begin
        case ($urandom_range(0, 9))
          0:       op = 16'h0000;
          1, 2, 3: op = 16'($urandom & $urandom & $urandom) & mask;
          default: op = 16'($urandom) & mask;
        endcase
        run_op(idx, op, int'($urandom_range(0, 2)), d, sh, z, lat, rdy);
        ref_model(len, left, op, ed, es, ez);
        n_cmp += 5;
        if (d !== ed) begin n_fail++; $display("FAIL rnd_dout[%0d] op=%h: got %h exp %h", idx, op, d, ed); end
        if (sh !== es) begin n_fail++; $display("FAIL rnd_shamt[%0d] op=%h: got %0d exp %0d", idx, op, sh, es); end
        if (z !== ez) begin n_fail++; $display("FAIL rnd_zero[%0d] op=%h: got %b exp %b", idx, op, z, ez); end
        if (lat !== s_a[idx]) begin n_fail++; $display("FAIL rnd_latency[%0d] op=%h: got %0d exp %0d", idx, op, lat, s_a[idx]); end
        if (rdy !== 1'b1) begin n_fail++; $display("FAIL rnd_ready_after[%0d]: got %b exp 1", idx, rdy); end
        if (op != 16'h0000) begin
          inv = left ? (d >> sh) : ((d << sh) & mask);
          edge_bit = left ? d[len-1] : d[0];
          n_cmp += 2;
          if (inv !== op) begin n_fail++; $display("FAIL rnd_invariant[%0d]: got %h exp %h", idx, inv, op); end
          if (edge_bit !== 1'b1) begin n_fail++; $display("FAIL rnd_edge_bit[%0d] op=%h: got %b exp 1", idx, op, edge_bit); end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b0; data_in_a[i] = 16'h0000;
    end
    test_reset();
    test_basic();
    test_left_edges();
    test_right();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
